// File: rtl/lut3_cfg_programmer.sv
// Programs a 3-input LUT from an 8-bit truth table, then sweeps all
// eight input vectors and reports a per-vector mismatch mask.
module lut3_cfg_programmer #(
  parameter int LUT_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  output logic       lut_enable,
  output logic [7:0] lut_s,
  output logic       lut_a,
  output logic       lut_b,
  output logic       lut_c,
  input  logic       lut_z,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_DONE
  } state_t;

  localparam logic [2:0] LAT3 = 3'(LUT_LAT);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_shadow;
  logic [7:0] r_lut_s;
  logic       r_en;
  logic [2:0] r_vec;
  logic [2:0] r_wait;
  logic       r_pass;
  logic [7:0] r_mask;

  logic       w_accept;
  logic       w_sample;
  logic       w_miss;
  logic [7:0] w_mask_nxt;

  assign w_accept   = cfg_valid && (r_state == S_IDLE);
  assign w_sample   = (r_state == S_SWEEP) && (r_wait == LAT3);
  assign w_miss     = lut_z != r_shadow[r_vec];
  assign w_mask_nxt = r_mask | (8'(w_miss) << r_vec);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LOAD;
      S_LOAD:  w_next = S_SWEEP;
      S_SWEEP: if (w_sample && r_vec == 3'd7) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_lut_s  <= '0;
      r_en     <= 1'b0;
      r_vec    <= '0;
      r_wait   <= '0;
      r_pass   <= 1'b0;
      r_mask   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shadow <= cfg_data;
            r_pass   <= 1'b0;
            r_mask   <= '0;
          end
        end
        S_LOAD: begin
          r_lut_s <= r_shadow;
          r_en    <= 1'b1;
          r_vec   <= '0;
          r_wait  <= '0;
        end
        S_SWEEP: begin
          if (w_sample) begin
            r_mask <= w_mask_nxt;
            r_wait <= '0;
            // pass must already include the last vector while done is high
            if (r_vec == 3'd7) r_pass <= (w_mask_nxt == 8'h00);
            else               r_vec  <= r_vec + 3'd1;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_DONE: r_en <= 1'b0;
        default: ;
      endcase
    end
  end

  assign cfg_ready  = (r_state == S_IDLE);
  assign done       = (r_state == S_DONE);
  assign lut_enable = r_en;
  assign lut_s      = r_lut_s;
  assign lut_a      = r_vec[2];
  assign lut_b      = r_vec[1];
  assign lut_c      = r_vec[0];
  assign pass       = r_pass;
  assign fail_mask  = r_mask;

endmodule

// File: tb/tb_lut3_cfg_programmer.sv
// Directed bench: two programmers (LUT_LAT 1 and 3) driving behavioural
// LUT models that can be ideal, stuck-at-0, or flipped on vector 7.
module tb_lut3_cfg_programmer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v1 = 1'b0, v3 = 1'b0;
  logic [7:0] d1 = '0, d3 = '0;
  logic       cfg_ready1, cfg_ready3;
  logic       lut_enable1, lut_enable3;
  logic [7:0] lut_s1, lut_s3;
  logic       a1, b1, c1, a3, b3, c3;
  logic       z1, z3;
  logic       done1, done3, pass1, pass3;
  logic [7:0] fail_mask1, fail_mask3;

  lut3_cfg_programmer #(.LUT_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(v1), .cfg_ready(cfg_ready1), .cfg_data(d1),
    .lut_enable(lut_enable1), .lut_s(lut_s1),
    .lut_a(a1), .lut_b(b1), .lut_c(c1), .lut_z(z1),
    .done(done1), .pass(pass1), .fail_mask(fail_mask1)
  );

  lut3_cfg_programmer #(.LUT_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(v3), .cfg_ready(cfg_ready3), .cfg_data(d3),
    .lut_enable(lut_enable3), .lut_s(lut_s3),
    .lut_a(a3), .lut_b(b3), .lut_c(c3), .lut_z(z3),
    .done(done3), .pass(pass3), .fail_mask(fail_mask3)
  );

  // 0 = ideal, 1 = Z stuck at 0, 2 = Z inverted for vector 7 only
  int mode = 0;
  logic [2:0] abc1, abc3;
  logic       m1;
  logic [2:0] p3;
  assign abc1 = {a1, b1, c1};
  assign abc3 = {a3, b3, c3};
  always @(posedge clk) m1 <= lut_s1[abc1];
  always @(posedge clk) p3 <= {p3[1:0], lut_s3[abc3]};
  assign z1 = (mode == 1) ? 1'b0 :
              (mode == 2 && abc1 == 3'd7) ? ~m1 : m1;
  assign z3 = (mode == 1) ? 1'b0 : p3[2];

  logic [21:0] obs1;
  localparam logic [21:0] RST_OBS = {1'b1, 1'b0, 8'h00, 3'b000,
                                     1'b0, 1'b0, 8'h00};
  assign obs1 = {cfg_ready1, lut_enable1, lut_s1, abc1,
                 done1, pass1, fail_mask1};

  int n_cmp = 0;
  int n_bad = 0;

  // Offer a table; returns at the falling edge after the accept edge
  task automatic accept1(input logic [7:0] data, input bit hold);
    @(negedge clk);
    v1 = 1'b1;
    d1 = data;
    @(posedge clk);
    @(negedge clk);
    if (!hold) v1 = 1'b0;
  endtask

  // k = falling-edge index (accept edge's own cycle = 1) where done is seen
  task automatic wait_done1(output int k, output bit rdy_ok);
    k = 0;
    rdy_ok = 1'b1;
    for (int i = 2; i <= 60; i++) begin
      @(negedge clk);
      if (cfg_ready1) rdy_ok = 1'b0;
      if (done1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs1 !== RST_OBS) begin
      n_bad++;
      $display("FAIL reset_outs: got %h want %h", obs1, RST_OBS);
    end
    n_cmp++;
    if ({cfg_ready3, done3, fail_mask3} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_outs3: got %b %b %h want 1 0 00",
               cfg_ready3, done3, fail_mask3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_xor3();
    int k;
    bit r;
    mode = 0;
    accept1(8'h96, 1'b0);
    wait_done1(k, r);
    n_cmp++;
    if (k !== 18) begin
      n_bad++; $display("FAIL xor_latency: got %0d want 18", k);
    end
    n_cmp++;
    if ({pass1, fail_mask1, lut_s1, lut_enable1} !== {1'b1, 8'h00, 8'h96, 1'b1}) begin
      n_bad++;
      $display("FAIL xor_result: got pass=%b mask=%h s=%h en=%b want 1 00 96 1",
               pass1, fail_mask1, lut_s1, lut_enable1);
    end
    n_cmp++;
    if (r !== 1'b1) begin
      n_bad++; $display("FAIL xor_ready_low: got %b want 1", r);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cfg_ready1, lut_enable1, done1, pass1, lut_s1} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 8'h96}) begin
      n_bad++;
      $display("FAIL xor_idle: got rdy=%b en=%b done=%b pass=%b s=%h want 1 0 0 1 96",
               cfg_ready1, lut_enable1, done1, pass1, lut_s1);
    end
  endtask

  task automatic test_stuck0();
    int k;
    bit r;
    mode = 1;
    accept1(8'h96, 1'b0);
    wait_done1(k, r);
    n_cmp++;
    if ({k, pass1, fail_mask1} !== {32'd18, 1'b0, 8'h96}) begin
      n_bad++;
      $display("FAIL stuck0: got k=%0d pass=%b mask=%h want 18 0 96",
               k, pass1, fail_mask1);
    end
    mode = 0;
  endtask

  task automatic test_back_to_back();
    int k;
    bit r;
    accept1(8'h00, 1'b1);
    d1 = 8'hFF;
    wait_done1(k, r);
    n_cmp++;
    if ({k, pass1, r} !== {32'd18, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_first: got k=%0d pass=%b rdy_ok=%b want 18 1 1", k, pass1, r);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_ready1 !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready_gap: got %b want 1", cfg_ready1);
    end
    @(negedge clk);
    v1 = 1'b0;
    n_cmp++;
    if ({cfg_ready1, pass1} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_accept: got rdy=%b pass=%b want 0 0", cfg_ready1, pass1);
    end
    wait_done1(k, r);
    n_cmp++;
    if ({k, pass1, fail_mask1, lut_s1, r} !== {32'd18, 1'b1, 8'h00, 8'hFF, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_second: got k=%0d pass=%b mask=%h s=%h rdy_ok=%b want 18 1 00 ff 1",
               k, pass1, fail_mask1, lut_s1, r);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    bit r;
    bit seen;
    bit got_done;
    accept1(8'hE8, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (abc1 == 3'd4) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++; $display("FAIL rmid_reach_v4: got %b want 1", seen);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (obs1 !== RST_OBS) begin
      n_bad++;
      $display("FAIL rmid_outs: got %h want %h", obs1, RST_OBS);
    end
    got_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done1) got_done = 1'b1;
    end
    n_cmp++;
    if (got_done !== 1'b0) begin
      n_bad++; $display("FAIL rmid_no_done: got %b want 0", got_done);
    end
    accept1(8'hE8, 1'b0);
    wait_done1(k, r);
    n_cmp++;
    if ({k, pass1, fail_mask1, lut_s1} !== {32'd18, 1'b1, 8'h00, 8'hE8}) begin
      n_bad++;
      $display("FAIL rmid_fresh: got k=%0d pass=%b mask=%h s=%h want 18 1 00 e8",
               k, pass1, fail_mask1, lut_s1);
    end
  endtask

  task automatic test_lat3();
    int k;
    bit hold_ok;
    logic [2:0] exp_v;
    k = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    v3 = 1'b1;
    d3 = 8'h80;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    for (int i = 2; i <= 50; i++) begin
      @(negedge clk);
      if (i <= 33) begin
        exp_v = 3'((i - 2) / 4);
        if (abc3 !== exp_v) hold_ok = 1'b0;
      end
      if (done3) begin
        k = i;
        break;
      end
    end
    n_cmp++;
    if (k !== 34) begin
      n_bad++; $display("FAIL lat3_latency: got %0d want 34", k);
    end
    n_cmp++;
    if (hold_ok !== 1'b1) begin
      n_bad++; $display("FAIL lat3_vec_hold: got %b want 1", hold_ok);
    end
    n_cmp++;
    if ({pass3, fail_mask3, lut_s3} !== {1'b1, 8'h00, 8'h80}) begin
      n_bad++;
      $display("FAIL lat3_result: got pass=%b mask=%h s=%h want 1 00 80",
               pass3, fail_mask3, lut_s3);
    end
  endtask

  task automatic test_flip7();
    int k;
    bit r;
    mode = 2;
    accept1(8'h01, 1'b0);
    wait_done1(k, r);
    n_cmp++;
    if ({k, pass1, fail_mask1} !== {32'd18, 1'b0, 8'h80}) begin
      n_bad++;
      $display("FAIL flip7: got k=%0d pass=%b mask=%h want 18 0 80",
               k, pass1, fail_mask1);
    end
    mode = 0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({pass1, fail_mask1, cfg_ready1} !== {1'b0, 8'h80, 1'b1}) begin
      n_bad++;
      $display("FAIL flip7_hold: got pass=%b mask=%h rdy=%b want 0 80 1",
               pass1, fail_mask1, cfg_ready1);
    end
  endtask

  initial begin
    test_reset();
    test_xor3();
    test_stuck0();
    test_back_to_back();
    test_reset_mid();
    test_lat3();
    test_flip7();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
